// File: rtl/shift_pkg.sv
// Shared constants and types for the serial shift path: default word width,
// bit-counter width helper and the deserializer state encoding.
package shift_pkg;

  localparam int DEF_WIDTH = 4;

  // Counter width for a WIDTH-bit word; never narrower than one bit.
  function automatic int cnt_w(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver; q/q_valid load on the edge sampling the last bit.
// One-deep output buffer: a word completing while q is unconsumed is dropped and flags overrun.
module shift_deserializer
  import shift_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        s_in,
  input  logic                        s_valid,
  input  logic                        msb_first,
  input  logic                        clear,
  output logic [WIDTH-1:0]            q,
  output logic                        q_valid,
  input  logic                        q_ready,
  output logic                        overrun,
  output logic [cnt_w(WIDTH)-1:0]     bit_count
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic             r_msb;

  logic             w_order;
  logic             w_last;
  logic             w_take;
  logic [WIDTH-1:0] w_next;

  // Bit order is taken live on the first bit of a word, then frozen in r_msb.
  assign w_order = (r_state == IDLE) ? msb_first : r_msb;
  assign w_last  = (bit_count == CW'(WIDTH - 1));
  assign w_take  = q_valid && q_ready;
  assign w_next  = w_order ? {r_shreg[WIDTH-2:0], s_in}
                           : {s_in, r_shreg[WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shreg   <= '0;
      r_msb     <= 1'b1;
      q         <= '0;
      q_valid   <= 1'b0;
      overrun   <= 1'b0;
      bit_count <= '0;
    end else begin
      if (w_take) begin
        q_valid <= 1'b0;
      end
      if (clear) begin
        r_state   <= IDLE;
        r_shreg   <= '0;
        bit_count <= '0;
        overrun   <= 1'b0;
      end else if (s_valid) begin
        if (r_state == IDLE) begin
          r_msb <= msb_first;
        end
        if (w_last) begin
          r_state   <= IDLE;
          r_shreg   <= '0;
          bit_count <= '0;
          // A same-edge consume frees the buffer for the new word.
          if (!q_valid || w_take) begin
            q       <= w_next;
            q_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
        end else begin
          r_state   <= SHIFT;
          r_shreg   <= w_next;
          bit_count <= bit_count + CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed vectors, a word-level reference model
// compared on every falling edge, plus literal expectations at key points.
module tb_shift_deserializer;

  localparam int W = 4;

  logic         clk;
  logic         reset;
  logic         s_in;
  logic         s_valid;
  logic         msb_first;
  logic         clear;
  logic [W-1:0] q;
  logic         q_valid;
  logic         q_ready;
  logic         overrun;
  logic [1:0]   bit_count;

  int n_tests = 0;
  int n_fail  = 0;

  shift_deserializer #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .s_in      (s_in),
    .s_valid   (s_valid),
    .msb_first (msb_first),
    .clear     (clear),
    .q         (q),
    .q_valid   (q_valid),
    .q_ready   (q_ready),
    .overrun   (overrun),
    .bit_count (bit_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words accumulated arithmetically, bit position by count.
  int m_q, m_acc, m_n;
  bit m_v, m_ov, m_ord;

  function automatic int next_acc(input int acc, input int n, input bit ord, input bit b);
    if (ord) return acc * 2 + int'(b);
    return acc + (b ? (1 << n) : 0);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q <= 0; m_acc <= 0; m_n <= 0; m_v <= 1'b0; m_ov <= 1'b0; m_ord <= 1'b1;
    end else begin
      if (m_v && q_ready) m_v <= 1'b0;
      if (clear) begin
        m_n <= 0; m_acc <= 0; m_ov <= 1'b0;
      end else if (s_valid) begin
        m_ord <= (m_n == 0) ? msb_first : m_ord;
        if (m_n == W - 1) begin
          m_n <= 0;
          m_acc <= 0;
          if (!m_v || q_ready) begin
            m_q <= next_acc(m_acc, m_n, (m_n == 0) ? msb_first : m_ord, s_in);
            m_v <= 1'b1;
          end else begin
            m_ov <= 1'b1;
          end
        end else begin
          m_n <= m_n + 1;
          m_acc <= next_acc(m_acc, m_n, (m_n == 0) ? msb_first : m_ord, s_in);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("model_q", int'(q), m_q);
    chk("model_q_valid", int'(q_valid), int'(m_v));
    chk("model_overrun", int'(overrun), int'(m_ov));
    chk("model_bit_count", int'(bit_count), m_n);
  end

  // Drives one cycle; inputs change 1 ns after the edge, results are read there.
  task automatic cyc(input bit b, input bit v);
    s_in = b;
    s_valid = v;
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  initial begin
    logic [W-1:0] words [4];
    bit           ords  [4];
    reset = 1'b1; s_in = 1'b0; s_valid = 1'b0; msb_first = 1'b1;
    clear = 1'b0; q_ready = 1'b0;
    words[0] = 4'h9; words[1] = 4'h3; words[2] = 4'hE; words[3] = 4'h5;
    ords[0] = 1'b1; ords[1] = 1'b0; ords[2] = 1'b0; ords[3] = 1'b1;

    #20 reset = 1'b0;
    @(posedge clk); #1;
    chk("rst_q", int'(q), 0);
    chk("rst_q_valid", int'(q_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_bit_count", int'(bit_count), 0);

    // MSB-first 1010 with bit_count sequence 1,2,3,0
    q_ready = 1'b1; msb_first = 1'b1;
    cyc(1, 1); chk("msb_bc1", int'(bit_count), 1);
    cyc(0, 1); chk("msb_bc2", int'(bit_count), 2);
    cyc(1, 1); chk("msb_bc3", int'(bit_count), 3);
    chk("msb_not_yet_valid", int'(q_valid), 0);
    cyc(0, 1); chk("msb_bc0", int'(bit_count), 0);
    chk("msb_q", int'(q), 'b1010);
    chk("msb_q_valid", int'(q_valid), 1);
    cyc(0, 0);
    chk("consume_q_valid", int'(q_valid), 0);
    chk("consume_q_held", int'(q), 'b1010);

    // LSB-first 1010 with a mid-word order toggle
    msb_first = 1'b0;
    cyc(1, 1);
    msb_first = 1'b1;
    cyc(0, 1); cyc(1, 1);
    msb_first = 1'b0;
    cyc(0, 1);
    chk("lsb_q", int'(q), 'b0101);
    chk("lsb_q_valid", int'(q_valid), 1);
    cyc(0, 0);

    // Overrun: two words with consumer stalled
    q_ready = 1'b0; msb_first = 1'b1;
    cyc(1, 1); cyc(1, 1); cyc(0, 1); cyc(0, 1);
    chk("ovr_first_q", int'(q), 'b1100);
    chk("ovr_first_overrun", int'(overrun), 0);
    cyc(0, 1); cyc(0, 1); cyc(1, 1); cyc(1, 1);
    chk("ovr_q_held", int'(q), 'b1100);
    chk("ovr_overrun", int'(overrun), 1);
    clear = 1'b1;
    cyc(0, 0);
    clear = 1'b0;
    chk("clr_overrun", int'(overrun), 0);
    chk("clr_q", int'(q), 'b1100);
    chk("clr_q_valid", int'(q_valid), 1);

    // Same-edge consume and load of 0110
    cyc(0, 1); cyc(1, 1); cyc(1, 1);
    q_ready = 1'b1;
    cyc(0, 1);
    chk("pass_q", int'(q), 'b0110);
    chk("pass_q_valid", int'(q_valid), 1);
    chk("pass_overrun", int'(overrun), 0);
    cyc(0, 0);

    // Clear with s_valid=1 discards the partial word
    cyc(1, 1); cyc(1, 1);
    clear = 1'b1;
    cyc(0, 1);
    clear = 1'b0;
    chk("clrsv_bit_count", int'(bit_count), 0);
    cyc(1, 1); cyc(1, 1); cyc(1, 1); cyc(1, 1);
    chk("clrsv_q", int'(q), 'b1111);

    // Reset pulse mid-word
    cyc(1, 1); cyc(0, 1);
    reset = 1'b1; #2 reset = 1'b0;
    chk("rstmid_bit_count", int'(bit_count), 0);
    chk("rstmid_q", int'(q), 0);
    for (int k = 0; k < 3; k++) begin
      cyc(1, 0);
      chk("rstmid_no_valid", int'(q_valid), 0);
    end

    // Back-to-back words, mixed order, a stall cycle in some words
    q_ready = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < W; i++) begin
        if (i == 0) msb_first = ords[w];
        else msb_first = ~ords[w];
        cyc(ords[w] ? words[w][W-1-i] : words[w][i], 1);
        if (w[0] && i == 1) cyc(0, 0);
      end
      chk("stream_q", int'(q), int'(words[w]));
    end
    cyc(0, 0); cyc(0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
